ps2_mouse_rx: RTL and testbench
===============================

PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, sets the inactivity limit in i_clk cycles (2 ms at 50 MHz).
REQ-002 i_clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_ps2_clk_neg  input  1  single-cycle pulse marking a falling edge of the debounced PS/2 clock.
REQ-005 i_ps2_data  input  1  debounced, synchronized PS/2 data line, sampled only when i_ps2_clk_neg=1.
REQ-006 o_valid  output  1  single-cycle pulse; packet outputs SHALL be valid in the same cycle.
REQ-007 o_btn  output  3  {middle, right, left} button state.
REQ-008 o_dx, o_dy  output  9 each  two's-complement movement, {sign bit from byte0, byte1 or byte2}.
REQ-009 o_ovf  output  2  {Y overflow, X overflow} from byte0 bits 7:6.
REQ-010 o_err  output  1  single-cycle pulse on any discarded frame or timeout.

Function
REQ-011 The frame FSM SHALL have states S_IDLE, S_DATA, S_PARITY, S_STOP and advance only on i_ps2_clk_neg.
REQ-012 S_IDLE: data=0 -> S_DATA, bit count 0; data=1 -> stay (glitch ignored, no o_err).
REQ-013 S_DATA SHALL shift 8 bits LSB-first, then go to S_PARITY; S_PARITY SHALL latch the parity bit, then go to S_STOP.
REQ-014 S_STOP: data=1 -> byte accepted; data=0 -> framing error: byte dropped, byte index cleared, o_err pulse; either case -> S_IDLE.
REQ-015 The packet assembler SHALL hold byte index 0..2; byte 0 with bit3=0 SHALL be discarded with index kept at 0 (resync), without o_err.
REQ-016 On acceptance of byte 2, o_valid SHALL pulse exactly one cycle after the i_ps2_clk_neg that sampled its stop bit, and the index SHALL wrap to 0.
REQ-017 o_btn/o_dx/o_dy/o_ovf SHALL be registered and hold their values until the next o_valid.
REQ-018 An inactivity counter SHALL reload to TIMEOUT_CYCLES-1 on each i_ps2_clk_neg and decrement otherwise, saturating at 0.
REQ-019 When the counter reaches 0 and (state != S_IDLE or index != 0): FSM -> S_IDLE, index -> 0, one o_err pulse.
REQ-020 If i_ps2_clk_neg coincides with the timeout cycle, the edge SHALL win: counter reloads and no timeout occurs.

Reset
REQ-021 Asserting i_rst_n=0 SHALL force S_IDLE, index 0, counter TIMEOUT_CYCLES-1, and all outputs 0, including mid-frame.
REQ-022 After reset release, no o_valid SHALL occur until a complete, well-formed 3-byte packet is received.

Configuration
REQ-023 With PS2_PARITY_CHECK_EN defined, a byte failing odd parity SHALL be dropped like a framing error (index cleared, o_err pulse).
REQ-024 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and no parity logic SHALL be synthesized.

Structure
REQ-025 Package ps2_pkg SHALL hold the frame-state enum, the byte0 bit-position constants (L=0, R=1, M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7), and a packet struct.
REQ-026 The frame FSM SHALL be sub-module ps2_byte_rx (outputs: byte, byte_valid, frame_err); ps2_mouse_rx SHALL do packet assembly and timeout.

Verification
REQ-027 Frames 0x29(p=0), 0x05(p=1), 0xFB(p=0) -> one o_valid; o_btn=3'b001, o_dx=+5, o_dy=-5 (9'h1FB), o_ovf=0.
REQ-028 First byte 0x00 (sync bit clear), then the REQ-027 packet -> 0x00 dropped, no o_err, a single o_valid with the REQ-027 values.
REQ-029 Byte 0x29 with stop bit 0 -> o_err pulse, no o_valid; a following valid packet decodes correctly.
REQ-030 Two bytes sent, then no clock edges for TIMEOUT_CYCLES cycles -> exactly one o_err; the next full packet gives o_valid.
REQ-031 With PS2_PARITY_CHECK_EN, 0x05 sent with parity 0 -> o_err, index reset; without the macro -> packet accepted.
REQ-032 Reset asserted after 5 data bits -> all outputs 0; a fresh packet after release decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 mouse receiver shared types: frame states, byte0 bit map, packet.
// PS2_PARITY_CHECK_EN (optional) enables odd-parity checking in ps2_byte_rx.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } frame_state_t;

  localparam int B_L    = 0;
  localparam int B_R    = 1;
  localparam int B_M    = 2;
  localparam int B_SYNC = 3;
  localparam int B_XS   = 4;
  localparam int B_YS   = 5;
  localparam int B_XO   = 6;
  localparam int B_YO   = 7;

  typedef struct packed {
    logic [1:0] ovf;
    logic [8:0] dy;
    logic [8:0] dx;
    logic [2:0] btn;
  } packet_t;

  function automatic packet_t decode(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    packet_t p;
    p.btn = {b0[B_M], b0[B_R], b0[B_L]};
    p.dx  = {b0[B_XS], b1};
    p.dy  = {b0[B_YS], b2};
    p.ovf = {b0[B_YO], b0[B_XO]};
    return p;
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_byte_rx.sv
// PS/2 frame receiver: start, 8 data bits LSB-first, parity, stop.
// PS2_PARITY_CHECK_EN adds odd-parity rejection; otherwise parity is ignored.
module ps2_byte_rx
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_neg,
  input  logic       ps2_data,
  input  logic       abort,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  frame_state_t state;
  logic [2:0]   bit_cnt;
  logic         stop_edge;
  logic         good;

`ifdef PS2_PARITY_CHECK_EN
  logic par_ok;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      rx_byte <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_ok  <= 1'b0;
`endif
    end else if (abort) begin
      state <= S_IDLE;
    end else if (ps2_clk_neg) begin
      unique case (state)
        S_IDLE: begin
          if (!ps2_data) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          rx_byte <= {ps2_data, rx_byte[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_PARITY;
        end
        S_PARITY: begin
          state  <= S_STOP;
`ifdef PS2_PARITY_CHECK_EN
          par_ok <= ^{rx_byte, ps2_data};
`endif
        end
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes fire in the stop-bit cycle so the assembler can register them once.
  assign stop_edge = ps2_clk_neg && (state == S_STOP) && !abort;

`ifdef PS2_PARITY_CHECK_EN
  assign good = ps2_data && par_ok;
`else
  assign good = ps2_data;
`endif

  assign byte_valid = stop_edge && good;
  assign frame_err  = stop_edge && !good;
  assign busy       = (state != S_IDLE);

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: 3-byte assembly, resync and inactivity timeout.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of bytes.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk_neg,
  input  logic       i_ps2_data,
  output logic       o_valid,
  output logic [2:0] o_btn,
  output logic [8:0] o_dx,
  output logic [8:0] o_dy,
  output logic [1:0] o_ovf,
  output logic       o_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic [1:0]    idx;
  logic [7:0]    b0;
  logic [7:0]    b1;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;
  logic          byte_busy;
  logic          timeout;
  packet_t       pkt;

  // An edge in the timeout cycle wins: the counter reloads instead.
  assign timeout = (tmo_cnt == '0) && !i_ps2_clk_neg
                && (byte_busy || (idx != 2'd0));

  assign pkt = decode(b0, b1, rx_byte);

  ps2_byte_rx u_byte_rx (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .ps2_clk_neg(i_ps2_clk_neg),
    .ps2_data   (i_ps2_data),
    .abort      (timeout),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (byte_busy)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= RELOAD;
    end else if (i_ps2_clk_neg) begin
      tmo_cnt <= RELOAD;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx     <= 2'd0;
      b0      <= '0;
      b1      <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_btn   <= '0;
      o_dx    <= '0;
      o_dy    <= '0;
      o_ovf   <= '0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (timeout || frame_err) begin
        idx   <= 2'd0;
        o_err <= 1'b1;
      end else if (byte_valid) begin
        unique case (idx)
          2'd0: begin
            if (rx_byte[B_SYNC]) begin
              b0  <= rx_byte;
              idx <= 2'd1;
            end
          end
          2'd1: begin
            b1  <= rx_byte;
            idx <= 2'd2;
          end
          2'd2: begin
            o_btn   <= pkt.btn;
            o_dx    <= pkt.dx;
            o_dy    <= pkt.dy;
            o_ovf   <= pkt.ovf;
            o_valid <= 1'b1;
            idx     <= 2'd0;
          end
          default: idx <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Randomized bench for ps2_mouse_rx against a packet-level reference model.
// Build with PS2_PARITY_CHECK_EN to exercise the parity-checking variant.
module tb_ps2_mouse_rx;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_neg = 1'b0;
  logic       ps2_data = 1'b1;
  logic       o_valid;
  logic       o_err;
  logic [2:0] o_btn;
  logic [8:0] o_dx;
  logic [8:0] o_dy;
  logic [1:0] o_ovf;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk_neg(clk_neg),
    .i_ps2_data   (ps2_data),
    .o_valid      (o_valid),
    .o_btn        (o_btn),
    .o_dx         (o_dx),
    .o_dy         (o_dy),
    .o_ovf        (o_ovf),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int btn;
    int dx;
    int dy;
    int ovf;
  } ev_t;

  ev_t  vq[$];
  int   eq[$];
  int   idx = 0;
  bit   mid_frame = 1'b0;
  int   last_s = 0;
  logic [7:0] m0 = '0;
  logic [7:0] m1 = '0;
  int   x_btn = 0, x_dx = 0, x_dy = 0, x_ovf = 0;
  int   vcount = 0, ecount = 0;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    bit ev;
    bit ee;
    ev = 1'b0;
    ee = 1'b0;
    if (rst_n) begin
      if (vq.size() > 0 && vq[0].c == cyc) begin
        ev = 1'b1;
        x_btn = vq[0].btn;
        x_dx  = vq[0].dx;
        x_dy  = vq[0].dy;
        x_ovf = vq[0].ovf;
        void'(vq.pop_front());
      end
      if (eq.size() > 0 && eq[0] == cyc) begin
        ee = 1'b1;
        void'(eq.pop_front());
      end
      if ((mid_frame || idx != 0) && cyc == last_s + T) begin
        ee = 1'b1;
        mid_frame = 1'b0;
        idx = 0;
      end
      vcount += int'(o_valid);
      ecount += int'(o_err);
      chk("valid", o_valid, ev);
      chk("err", o_err, ee);
      chk("btn", o_btn, x_btn);
      chk("dx", $signed(o_dx), x_dx);
      chk("dy", $signed(o_dy), x_dy);
      chk("ovf", o_ovf, x_ovf);
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic d);
    ps2_data = d;
    clk_neg = 1'b1;
    @(posedge clk);
    #1;
    clk_neg = 1'b0;
    ps2_data = 1'($urandom);
    last_s = cyc;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic par,
                            input logic stop);
    bit ok;
    ev_t e;
    ok = stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && ($countones({b, par}) % 2 == 1);
`endif
    if (!ok) begin
      eq.push_back(last_s);
      idx = 0;
    end else if (idx == 0) begin
      if (b[3]) begin
        m0 = b;
        idx = 1;
      end
    end else if (idx == 1) begin
      m1 = b;
      idx = 2;
    end else begin
      e.c   = last_s;
      e.btn = int'(m0) % 8;
      e.dx  = int'(m1) - (m0[4] ? 256 : 0);
      e.dy  = int'(b) - (m0[5] ? 256 : 0);
      e.ovf = int'(m0) / 64;
      vq.push_back(e);
      idx = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stop);
    pulse(1'b0);
    mid_frame = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gap($urandom_range(0, 3));
      pulse(b[i]);
    end
    gap($urandom_range(0, 3));
    pulse(par);
    gap($urandom_range(0, 3));
    pulse(stop);
    mid_frame = 1'b0;
    model_byte(b, par, stop);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    send_good(a);
    gap($urandom_range(0, 4));
    send_good(b);
    gap($urandom_range(0, 4));
    send_good(c);
    gap(3);
  endtask

  task automatic pin_ref(input string tag);
    chk({tag, "_btn"}, o_btn, 1);
    chk({tag, "_dx"}, o_dx, 9'h005);
    chk({tag, "_dy"}, o_dy, 9'h1FB);
    chk({tag, "_ovf"}, o_ovf, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_btn"}, o_btn, 0);
    chk({tag, "_dx"}, o_dx, 0);
    chk({tag, "_dy"}, o_dy, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
  endtask

  task automatic do_reset();
    clk_neg = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_zero("rst");
    idx = 0;
    mid_frame = 1'b0;
    x_btn = 0;
    x_dx = 0;
    x_dy = 0;
    x_ovf = 0;
    vq.delete();
    eq.delete();
    gap(3);
    rst_n = 1'b1;
    gap(2);
  endtask

  int v0, e0;
  logic [7:0] rb;
  logic rp, rs;

  initial begin
    gap(3);
    chk_zero("por");
    rst_n = 1'b1;
    gap(3);

    v0 = vcount; e0 = ecount;
    send_pkt(8'h29, 8'h05, 8'hFB);
    pin_ref("basic");
    chk("basic_nvalid", vcount - v0, 1);
    chk("basic_nerr", ecount - e0, 0);

    v0 = vcount; e0 = ecount;
    send_good(8'h00);
    send_pkt(8'h29, 8'h05, 8'hFB);
    pin_ref("resync");
    chk("resync_nvalid", vcount - v0, 1);
    chk("resync_nerr", ecount - e0, 0);

    v0 = vcount; e0 = ecount;
    send_frame(8'h29, 1'b0, 1'b0);
    gap(3);
    chk("frame_nerr", ecount - e0, 1);
    chk("frame_nvalid", vcount - v0, 0);
    send_pkt(8'h29, 8'h05, 8'hFB);
    pin_ref("frame");

    v0 = vcount; e0 = ecount;
    send_good(8'h29);
    send_good(8'h05);
    gap(T + 5);
    chk("tmo_nerr", ecount - e0, 1);
    send_pkt(8'h29, 8'h05, 8'hFB);
    chk("tmo_nvalid", vcount - v0, 1);

    v0 = vcount; e0 = ecount;
    send_good(8'h29);
    wait_to(last_s + T - 1);
    send_good(8'h05);
    gap(1);
    send_good(8'hFB);
    gap(3);
    chk("edge_wins_nerr", ecount - e0, 0);
    chk("edge_wins_nvalid", vcount - v0, 1);

    v0 = vcount; e0 = ecount;
    send_good(8'h29);
    send_frame(8'h05, 1'b0, 1'b1);
    send_good(8'hFB);
    gap(T + 5);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_nvalid", vcount - v0, 0);
    chk("par_nerr", ecount - e0, 2);
`else
    chk("par_nvalid", vcount - v0, 1);
    chk("par_nerr", ecount - e0, 0);
`endif

    pulse(1'b0);
    mid_frame = 1'b1;
    for (int i = 0; i < 5; i++) pulse(1'($urandom));
    do_reset();
    send_pkt(8'h29, 8'h05, 8'hFB);
    pin_ref("after_rst");

    e0 = ecount;
    pulse(1'b0);
    mid_frame = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1'($urandom));
    gap(T + 5);
    chk("partial_nerr", ecount - e0, 1);

    e0 = ecount;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1);
      gap(2);
    end
    gap(3);
    chk("glitch_nerr", ecount - e0, 0);

    for (int p = 0; p < 60; p++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 11))
          0:       wait_to(last_s + T - 1);
          1:       wait_to(last_s + T);
          default: gap($urandom_range(0, 6));
        endcase
        if ($urandom_range(0, 9) == 0) begin
          pulse(1'b1);
          gap(1);
        end
        rb = 8'($urandom);
        if (k == 0 && $urandom_range(0, 5) != 0) rb[3] = 1'b1;
        rp = ~^rb;
        if ($urandom_range(0, 9) == 0) rp = ~rp;
        rs = ($urandom_range(0, 11) != 0);
        send_frame(rb, rp, rs);
      end
    end

    gap(T + 5);
    chk("pending", vq.size() + eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
